// File: rtl/ram_arbiter.sv
// ram_arbiter: grants the single shared RAM port to one of four cache miss
// requesters (core0 I/D, core1 I/D). D beats I within a core, and the cores
// rotate round-robin. Optional grant watchdog: define ARB_WATCHDOG_EN.

package ram_arbiter_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

module ram_arbiter #(
  parameter int unsigned WDOG_LIMIT = 64
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic [1:0]                 iREN,
  input  logic [1:0]                 dREN,
  input  logic [1:0]                 dWEN,
  input  logic [1:0][31:0]           iaddr,
  input  logic [1:0][31:0]           daddr,
  input  logic [1:0][31:0]           dstore,
  input  ram_arbiter_pkg::ramstate_t ramstate,
  input  logic [31:0]                ramload,
  output logic [1:0]                 iwait,
  output logic [1:0]                 dwait,
  output logic [1:0][31:0]           iload,
  output logic [1:0][31:0]           dload,
  output logic [31:0]                ramaddr,
  output logic [31:0]                ramstore,
  output logic                       ramREN,
  output logic                       ramWEN,
  output logic                       arb_timeout
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  arb_state_t state_q, state_d;
  logic [1:0] owner_q, owner_d;        // {core, is_data}
  logic       last_core_q, last_core_d;

  logic [1:0] req_d;
  logic       own_core, own_is_d, own_req, access;
  logic       pref, pick_core, any_req;
  logic       wdog_fire;

  assign req_d     = dREN | dWEN;
  assign own_core  = owner_q[1];
  assign own_is_d  = owner_q[0];
  assign own_req   = own_is_d ? req_d[own_core] : iREN[own_core];
  assign access    = (ramstate == ram_arbiter_pkg::ACCESS);
  assign pref      = ~last_core_q;
  assign pick_core = (req_d[pref] | iREN[pref]) ? pref : ~pref;
  assign any_req   = |(req_d | iREN);

  assign iload = {ramload, ramload};
  assign dload = {ramload, ramload};

`ifdef ARB_WATCHDOG_EN
  localparam int unsigned CW = $clog2(WDOG_LIMIT) + 1;

  logic [CW-1:0] wdog_q;
  logic          timeout_q;

  assign wdog_fire   = (state_q == ST_BUSY) && (wdog_q == CW'(WDOG_LIMIT));
  assign arb_timeout = timeout_q;

  // Count stalled BUSY cycles of the current grant; flag sticks once the limit is hit
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE) begin
        wdog_q <= '0;
      end else if (!access && (wdog_q != CW'(WDOG_LIMIT))) begin
        wdog_q <= wdog_q + CW'(1);
      end
      if ((state_q == ST_BUSY) && !access && own_req &&
          (wdog_q == CW'(WDOG_LIMIT - 1))) begin
        timeout_q <= 1'b1;
      end
    end
  end
`else
  logic unused_wdog;

  assign unused_wdog = ^WDOG_LIMIT;
  assign wdog_fire   = 1'b0;
  assign arb_timeout = 1'b0;
`endif

  // State, owner and round-robin pointer registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= ST_IDLE;
      owner_q     <= 2'b00;
      last_core_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_core_q <= last_core_d;
    end
  end

  // Arbitration, release conditions and RAM/wait routing for the current owner
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_core_d = last_core_q;
    iwait       = 2'b11;
    dwait       = 2'b11;
    ramaddr     = '0;
    ramstore    = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d = {pick_core, req_d[pick_core]};
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (own_is_d) begin
          ramaddr  = daddr[own_core];
          ramstore = dstore[own_core];
          ramWEN   = dWEN[own_core];
          ramREN   = dREN[own_core] & ~dWEN[own_core];
        end else begin
          ramaddr  = iaddr[own_core];
          ramREN   = 1'b1;
        end
        if (access) begin
          if (own_is_d) dwait[own_core] = 1'b0;
          else          iwait[own_core] = 1'b0;
          state_d     = ST_IDLE;
          last_core_d = own_core;
        end else if (!own_req) begin
          state_d = ST_IDLE;
        end else if (wdog_fire) begin
          state_d     = ST_IDLE;
          last_core_d = own_core;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios followed by random
// traffic, all checked against a transaction-level reference model.
// Watchdog scenario expectations follow ARB_WATCHDOG_EN.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [1:0]       iREN, dREN, dWEN;
  logic [1:0][31:0] iaddr, daddr, dstore;
  ramstate_t        ramstate;
  logic [31:0]      ramload;
  logic [1:0]       iwait, dwait;
  logic [1:0][31:0] iload, dload;
  logic [31:0]      ramaddr, ramstore;
  logic             ramREN, ramWEN, arb_timeout;

  int compared   = 0;
  int mismatched = 0;

  // reference model: a grant is (core, data?) plus who was served last
  bit m_busy, m_core, m_d, m_last, m_to;
  int m_cnt;

  // outputs captured at the check point of the most recent cycle
  logic [31:0] cap_addr, cap_store;
  logic        cap_ren, cap_wen, cap_to;
  logic [1:0]  cap_iwait, cap_dwait;
  bit          seen_c1;

  ram_arbiter dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore), .ramstate(ramstate),
    .ramload(ramload), .iwait(iwait), .dwait(dwait), .iload(iload),
    .dload(dload), .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN),
    .ramWEN(ramWEN), .arb_timeout(arb_timeout)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_core = 0; m_d = 0; m_last = 1; m_to = 0; m_cnt = 0;
  endtask

  function automatic bit wants(input bit core, input bit is_d);
    return is_d ? (dREN[core] | dWEN[core]) : iREN[core];
  endfunction

  task automatic check_model();
    logic [31:0] e_addr, e_store;
    logic        e_ren, e_wen;
    logic [1:0]  e_iw, e_dw;
    e_addr = 0; e_store = 0; e_ren = 0; e_wen = 0; e_iw = 2'b11; e_dw = 2'b11;
    if (m_busy) begin
      if (m_d) begin
        e_addr  = daddr[m_core];
        e_store = dstore[m_core];
        e_wen   = dWEN[m_core];
        e_ren   = dREN[m_core] & ~dWEN[m_core];
        if (ramstate == ACCESS) e_dw[m_core] = 1'b0;
      end else begin
        e_addr = iaddr[m_core];
        e_ren  = 1'b1;
        if (ramstate == ACCESS) e_iw[m_core] = 1'b0;
      end
    end
    chk("ramaddr", ramaddr, e_addr);
    chk("ramstore", ramstore, e_store);
    chk("ramREN", 32'(ramREN), 32'(e_ren));
    chk("ramWEN", 32'(ramWEN), 32'(e_wen));
    chk("iwait", 32'(iwait), 32'(e_iw));
    chk("dwait", 32'(dwait), 32'(e_dw));
    chk("arb_timeout", 32'(arb_timeout), 32'(m_to));
    chk("iload1", iload[1], ramload);
    chk("dload0", dload[0], ramload);
  endtask

  // advance the model by one clock using the inputs currently applied
  task automatic model_next();
    bit c;
    if (!m_busy) begin
      for (int k = 0; k < 4; k++) begin
        c = (k < 2) ? ~m_last : m_last;
        if (!m_busy && wants(c, (k % 2) == 0)) begin
          m_busy = 1; m_core = c; m_d = ((k % 2) == 0); m_cnt = 0;
        end
      end
    end else if (ramstate == ACCESS) begin
      m_busy = 0; m_last = m_core;
    end else if (!wants(m_core, m_d)) begin
      m_busy = 0;
    end else begin
`ifdef ARB_WATCHDOG_EN
      if (m_cnt == 64) begin
        m_busy = 0; m_last = m_core;
      end else begin
        m_cnt++;
        if (m_cnt == 64) m_to = 1;
      end
`else
      m_cnt++;
`endif
    end
  endtask

  // one clock: check at the falling edge, then step the model across the rising edge
  task automatic cycle();
    @(negedge CLK); #1;
    cap_addr = ramaddr; cap_store = ramstore; cap_ren = ramREN; cap_wen = ramWEN;
    cap_iwait = iwait; cap_dwait = dwait; cap_to = arb_timeout;
    check_model();
    model_next();
    @(posedge CLK); #1;
  endtask

  initial begin
    nRST = 0; iREN = 2'b11; dREN = 2'b11; dWEN = 2'b00; ramstate = ACCESS;
    ramload = 32'h1234_5678; iaddr = '0; dstore = '0;
    daddr[0] = 32'hA0; daddr[1] = 32'hB0;
    model_reset();

    // reset held with requests active
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_iwait", 32'(iwait), 32'h3);
    chk("rst_dwait", 32'(dwait), 32'h3);
    chk("rst_ren", 32'(ramREN), 32'h0);
    chk("rst_wen", 32'(ramWEN), 32'h0);
    chk("rst_addr", ramaddr, 32'h0);
    chk("rst_store", ramstore, 32'h0);
    chk("rst_timeout", 32'(arb_timeout), 32'h0);
    @(posedge CLK); #1;
    nRST = 1; iREN = 2'b00;

    // round robin from reset: core0 first, then alternate every 2 cycles
    for (int n = 0; n < 8; n++) begin
      cycle();
      if (n % 2 == 1) begin
        chk("rr_owner", cap_addr, (n % 4 == 1) ? 32'hA0 : 32'hB0);
        chk("rr_dwait", 32'(cap_dwait), (n % 4 == 1) ? 32'h2 : 32'h1);
      end else begin
        chk("rr_idle_ren", 32'(cap_ren), 32'h0);
      end
    end

    // single instruction read with ACCESS two cycles after grant
    dREN = 2'b00; iREN = 2'b01; iaddr[0] = 32'h100; ramstate = FREE;
    cycle();
    chk("rd_grant_ren", 32'(cap_ren), 32'h0);
    cycle();
    chk("rd_ren", 32'(cap_ren), 32'h1);
    chk("rd_addr", cap_addr, 32'h100);
    chk("rd_wait_hold", 32'(cap_iwait), 32'h3);
    ramstate = ACCESS;
    cycle();
    chk("rd_wait_done", 32'(cap_iwait), 32'h2);
    iREN = 2'b00;
    cycle();
    chk("rd_idle_ren", 32'(cap_ren), 32'h0);

    // data beats instruction within core0
    iREN = 2'b01; dWEN = 2'b01; daddr[0] = 32'h200; dstore[0] = 32'hDEADBEEF;
    cycle();
    cycle();
    chk("pri_wen", 32'(cap_wen), 32'h1);
    chk("pri_ren", 32'(cap_ren), 32'h0);
    chk("pri_store", cap_store, 32'hDEADBEEF);
    chk("pri_addr", cap_addr, 32'h200);
    chk("pri_dwait", 32'(cap_dwait), 32'h2);
    dWEN = 2'b00;
    cycle();
    chk("pri_idle_wen", 32'(cap_wen), 32'h0);
    cycle();
    chk("pri_i_addr", cap_addr, 32'h100);
    chk("pri_i_iwait", 32'(cap_iwait), 32'h2);
    iREN = 2'b00;

    // abandon: core1 drops its read while RAM is busy
    dREN = 2'b10; daddr[1] = 32'h300; ramstate = BUSY;
    cycle();
    cycle();
    chk("ab_addr", cap_addr, 32'h300);
    chk("ab_dwait_busy", 32'(cap_dwait), 32'h3);
    dREN = 2'b00;
    cycle();
    chk("ab_dwait_drop", 32'(cap_dwait), 32'h3);
    cycle();
    // last_core still core0, so core1 is preferred next
    iREN = 2'b11; iaddr[1] = 32'h400; ramstate = ACCESS;
    cycle();
    cycle();
    chk("ab_next_owner", cap_addr, 32'h400);
    chk("ab_next_iwait", 32'(cap_iwait), 32'h1);
    iREN = 2'b00;
    cycle();

    // stuck RAM: core0 granted, core1 pending
    dREN = 2'b01; daddr[0] = 32'h500; daddr[1] = 32'h600; ramstate = BUSY;
    cycle();
    dREN = 2'b11; seen_c1 = 0;
    for (int n = 0; n < 72; n++) begin
      cycle();
      if (cap_ren && cap_addr == 32'h600) seen_c1 = 1;
    end
`ifdef ARB_WATCHDOG_EN
    chk("wd_flag", 32'(cap_to), 32'h1);
    chk("wd_core1_granted", 32'(seen_c1), 32'h1);
`else
    chk("wd_flag_off", 32'(cap_to), 32'h0);
    chk("wd_still_core0", cap_addr, 32'h500);
`endif

    // asynchronous reset in the middle of a grant
    nRST = 0;
    #1;
    chk("arst_ren", 32'(ramREN), 32'h0);
    chk("arst_wen", 32'(ramWEN), 32'h0);
    chk("arst_addr", ramaddr, 32'h0);
    chk("arst_dwait", 32'(dwait), 32'h3);
    chk("arst_timeout", 32'(arb_timeout), 32'h0);
    model_reset();
    nRST = 1;

    // random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      int r;
      iREN = 2'($urandom_range(0, 3));
      dREN = 2'($urandom_range(0, 3));
      dWEN = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      for (int c = 0; c < 2; c++) begin
        iaddr[c] = $urandom; daddr[c] = $urandom; dstore[c] = $urandom;
      end
      ramload = $urandom;
      r = $urandom_range(0, 9);
      ramstate = (r < 4) ? ACCESS : (r < 7) ? BUSY : (r < 9) ? FREE : ERROR;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
